// File: rtl/sdram_frame_writer_if.sv
// rtl/sdram_frame_writer_if.sv - write-request handshake between the frame writer and sdram_top
//  wr_sdram_req : request, held high until the burst is acknowledged
//  wr_sdram_ack : 1-cycle pulse, burst finished
//  wr_sdram_add : {bank[1:0], row[12:0], col[8:0]}
interface sdram_frame_writer_if;
    logic        wr_sdram_req;
    logic        wr_sdram_ack;
    logic [23:0] wr_sdram_add;

    modport master (output wr_sdram_req, output wr_sdram_add, input wr_sdram_ack);
    modport slave  (input wr_sdram_req, input wr_sdram_add, output wr_sdram_ack);
endinterface

// File: rtl/sdram_frame_writer.sv
// rtl/sdram_frame_writer.sv - camera-side SDRAM write sequencer, one burst request per row
//  clk, rst_133        : 133 MHz clock, async active-low reset
//  frame_start, cam_en : frame-start pulse and camera-ready level
//  wr_bank, fifo_used  : bank for next frame, write-FIFO fill level
//  sdram (master)      : req/ack/address handshake towards sdram_top
//  clear_wrsdram_fifo, frame_done, busy, row_cnt, err_overflow, err_timeout : status
module sdram_frame_writer #(
    parameter int BURST_LEN      = 512,
    parameter int ROWS_PER_FRAME = 750,
    parameter int FIFO_AW        = 11,
    parameter int ACK_TIMEOUT    = 4095
) (
    input  logic                 clk,
    input  logic                 rst_133,
    input  logic                 frame_start,
    input  logic                 cam_en,
    input  logic [1:0]           wr_bank,
    input  logic [FIFO_AW-1:0]   fifo_used,
    sdram_frame_writer_if.master sdram,
    output logic                 clear_wrsdram_fifo,
    output logic                 frame_done,
    output logic                 busy,
    output logic [12:0]          row_cnt,
    output logic                 err_overflow,
    output logic                 err_timeout
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_REQ  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int                 TO_W      = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TO_W-1:0]    TO_MAX    = TO_W'(ACK_TIMEOUT);
    localparam logic [TO_W-1:0]    TO_PRE    = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [FIFO_AW-1:0] BURST_THR = FIFO_AW'(BURST_LEN);
    localparam logic [FIFO_AW-1:0] FIFO_FULL = '1;
    localparam logic [12:0]        ROWS_END  = 13'(ROWS_PER_FRAME);

    logic [1:0]         state_q, state_d;
    logic               req_q, req_d;
    logic [23:0]        add_q, add_d;
    logic               clear_q, clear_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               to_err_q, to_err_d;
    logic               pend_q, pend_d;
    logic [1:0]         pend_bank_q, pend_bank_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [FIFO_AW-1:0] fifo_q;

    logic        start_now;
    logic [1:0]  start_bank;
    logic [12:0] row_next;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        add_d       = add_q;
        clear_d     = 1'b0;
        done_d      = 1'b0;
        ovf_d       = ovf_q;
        to_err_d    = to_err_q;
        pend_d      = pend_q;
        pend_bank_d = pend_bank_q;
        to_cnt_d    = '0;
        start_now   = 1'b0;
        start_bank  = wr_bank;
        row_next    = add_q[21:9] + 13'd1;

        if ((state_q == S_WAIT || state_q == S_REQ) && fifo_q == FIFO_FULL)
            ovf_d = 1'b1;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (frame_start) start_now = 1'b1;
            end
            S_WAIT: begin
                if (frame_start) begin
                    start_now = 1'b1;
                end else if (fifo_q >= BURST_THR && add_q[21:9] < ROWS_END) begin
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (sdram.wr_sdram_ack) begin
                    req_d = 1'b0;
                    // A restart requested during this burst replaces the row advance;
                    // a start pulse arriving on the ack cycle itself is the newest bank.
                    if (pend_q || frame_start) begin
                        start_now  = 1'b1;
                        start_bank = frame_start ? wr_bank : pend_bank_q;
                    end else begin
                        add_d[21:9] = row_next;
                        if (row_next == ROWS_END) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end else begin
                    if (frame_start) begin
                        pend_d      = 1'b1;
                        pend_bank_d = wr_bank;
                    end
                    // Saturating count; the error flag is raised on the cycle it hits the limit.
                    to_cnt_d = to_cnt_q;
                    if (to_cnt_q != TO_MAX) begin
                        to_cnt_d = to_cnt_q + 1'b1;
                        if (to_cnt_q == TO_PRE) to_err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start_now) begin
            clear_d  = 1'b1;
            add_d    = {start_bank, 22'd0};
            ovf_d    = 1'b0;
            to_err_d = 1'b0;
            pend_d   = 1'b0;
            req_d    = 1'b0;
            to_cnt_d = '0;
            state_d  = cam_en ? S_WAIT : S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_133) begin
        if (!rst_133) begin
            state_q     <= S_IDLE;
            req_q       <= 1'b0;
            add_q       <= '0;
            clear_q     <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            to_err_q    <= 1'b0;
            pend_q      <= 1'b0;
            pend_bank_q <= 2'd0;
            to_cnt_q    <= '0;
            fifo_q      <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            add_q       <= add_d;
            clear_q     <= clear_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            to_err_q    <= to_err_d;
            pend_q      <= pend_d;
            pend_bank_q <= pend_bank_d;
            to_cnt_q    <= to_cnt_d;
            fifo_q      <= fifo_used;
        end
    end

    assign sdram.wr_sdram_req = req_q;
    assign sdram.wr_sdram_add = add_q;
    assign clear_wrsdram_fifo = clear_q;
    assign frame_done         = done_q;
    assign busy               = (state_q == S_WAIT) || (state_q == S_REQ);
    assign row_cnt            = add_q[21:9];
    assign err_overflow       = ovf_q;
    assign err_timeout        = to_err_q;
endmodule
